// File: rtl/mips_cpu_mem_access.sv
// Data-memory access stage: decodes MIPS loads/stores, runs one waitrequest-handshaked bus cycle per request.
// Optional misalignment trap when MEM_ACCESS_ALIGN_CHECK_EN is defined (adds the fault output).
module mips_cpu_mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic [31:0] instruction,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        done,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_byteenable,
  output logic [31:0] data_writedata,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state;
  logic [5:0]  op;
  logic [1:0]  a;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        is_half;
  logic        is_word;
  logic [1:0]  eff_off;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic        ld_q;
  logic [1:0]  off_q;
  logic [31:0] shifted;
  logic [31:0] aligned;
  logic        unused_instr;

  assign unused_instr = ^instruction[25:0];

  always_comb begin
    op       = instruction[31:26];
    a        = address[1:0];
    is_load  = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    is_mem   = is_load || is_store;
    is_half  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    is_word  = (op == OP_LW) || (op == OP_SW);
    // Halfword accesses drop a[0], word accesses use lane 0; bytes use a as-is.
    if (is_half)      eff_off = {a[1], 1'b0};
    else if (is_word) eff_off = 2'b00;
    else              eff_off = a;
    case (op)
      OP_SB: begin
        be_c = 4'b0001 << eff_off;
        wd_c = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be_c = 4'b0011 << eff_off;
        wd_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = store_data;
      end
    endcase
  end

  assign stall = mem_req && is_mem && (state != DONE);

  // Bring the addressed byte to bit 0, then byte-reverse so it lands in [31:24].
  assign shifted = data_readdata >> {off_q, 3'b000};
  assign aligned = {shifted[7:0], shifted[15:8], shifted[23:16], shifted[31:24]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      read_data       <= 32'h0;
      done            <= 1'b0;
      data_read       <= 1'b0;
      data_write      <= 1'b0;
      data_byteenable <= 4'h0;
      data_address    <= 32'h0;
      data_writedata  <= 32'h0;
      ld_q            <= 1'b0;
      off_q           <= 2'b00;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      fault           <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_req && is_mem) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            if ((is_half && a[0]) || (is_word && (a != 2'b00))) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
`endif
              state           <= BUS;
              ld_q            <= is_load;
              off_q           <= eff_off;
              data_address    <= {address[31:2], 2'b00};
              data_read       <= is_load;
              data_write      <= is_store;
              data_byteenable <= be_c;
              data_writedata  <= wd_c;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            end
`endif
          end
        end
        BUS: begin
          if (!data_waitrequest) begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            if (ld_q) read_data <= aligned;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
